saturn_bus_ctrl: RTL and testbench

- CPU-side nibble-bus master.
- Turns core fetch and data requests into Saturn bus command and data cycles: it drives strobe, cmd/data and nibble out, and samples the returned nibbles.
- Sits directly upstream of the ROM and other bus slaves, which act on the rising strobe edge.
- Tracks the slave's PC pointer so sequential fetches skip re-issuing LOAD_PC.

---
 rtl/saturn_bus_ctrl_pkg.sv | 32 +++
 rtl/saturn_bus_ctrl_cycle.sv | 70 +++++++
 rtl/saturn_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_saturn_bus_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/saturn_bus_ctrl_pkg.sv
// Shared definitions for the Saturn nibble-bus master: bus command codes,
// core-side operation codes and the transaction FSM encoding.
package saturn_bus_ctrl_pkg;

  localparam logic [3:0] BUSCMD_NOP      = 4'h0;
  localparam logic [3:0] BUSCMD_DP_READ  = 4'h3;
  localparam logic [3:0] BUSCMD_DP_WRITE = 4'h5;
  localparam logic [3:0] BUSCMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] BUSCMD_LOAD_DP  = 4'h7;

  localparam int ADDR_NIBBLES = 5;

  typedef enum logic [1:0] {
    BUSOP_READ_PC  = 2'd0,
    BUSOP_READ_DP  = 2'd1,
    BUSOP_WRITE_DP = 2'd2
  } busop_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT0 = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_CMD2  = 3'd4,
    S_DATA  = 3'd5
  } state_t;

  function automatic logic op_legal(input logic [1:0] op);
    return op != 2'd3;
  endfunction

endpackage

// File: rtl/saturn_bus_ctrl_cycle.sv
// One Saturn bus cycle: loads cmd/data at phase 0, raises strobe at phase 1,
// drops strobe and optionally samples the slave nibble at phase 3.
module saturn_bus_cycle
  import saturn_bus_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_phase,
  input  logic       i_start,
  input  logic       i_cmd_data,
  input  logic [3:0] i_nibble,
  input  logic       i_capture,
  input  logic [3:0] i_bus_data_in,
  output logic       o_strobe,
  output logic       o_cmd_data,
  output logic [3:0] o_data_out,
  output logic [3:0] o_sample,
  output logic       o_cycle_end
);

  logic       active_q, active_d;
  logic       strobe_q, strobe_d;
  logic       cmd_data_q, cmd_data_d;
  logic [3:0] data_q, data_d;
  logic [3:0] sample_q, sample_d;

  // Asserted during the clock whose rising edge is this cycle's phase-3 edge.
  assign o_cycle_end = active_q && (i_phase == 2'd3);

  always_comb begin
    active_d   = active_q;
    strobe_d   = strobe_q;
    cmd_data_d = cmd_data_q;
    data_d     = data_q;
    sample_d   = sample_q;
    if (i_start) begin
      active_d   = 1'b1;
      cmd_data_d = i_cmd_data;
      data_d     = i_nibble;
    end
    if (active_q && (i_phase == 2'd1)) strobe_d = 1'b1;
    if (o_cycle_end) begin
      strobe_d = 1'b0;
      active_d = 1'b0;
      if (i_capture) sample_d = i_bus_data_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      active_q   <= 1'b0;
      strobe_q   <= 1'b0;
      cmd_data_q <= 1'b0;
      data_q     <= BUSCMD_NOP;
      sample_q   <= 4'h0;
    end else begin
      active_q   <= active_d;
      strobe_q   <= strobe_d;
      cmd_data_q <= cmd_data_d;
      data_q     <= data_d;
      sample_q   <= sample_d;
    end
  end

  assign o_strobe   = strobe_q;
  assign o_cmd_data = cmd_data_q;
  assign o_data_out = data_q;
  assign o_sample   = sample_q;

endmodule

// File: rtl/saturn_bus_ctrl.sv
// CPU-side Saturn nibble-bus master: turns core read/write requests into
// command/address/data bus cycles and skips LOAD_PC on sequential PC fetches.
module saturn_bus_ctrl
  import saturn_bus_ctrl_pkg::*;
#(
  parameter  int MAXLEN = 16,
  localparam int LEN_W  = $clog2(MAXLEN)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_phase,
  input  logic                  i_req,
  input  logic [1:0]            i_op,
  input  logic [19:0]           i_addr,
  input  logic [LEN_W-1:0]      i_len,
  input  logic [4*MAXLEN-1:0]   i_wdata,
  output logic                  o_ack,
  output logic                  o_busy,
  output logic                  o_rd_valid,
  output logic [3:0]            o_rd_nibble,
  output logic [LEN_W-1:0]      o_rd_index,
  output logic                  o_done,
  output logic                  o_bus_strobe,
  output logic                  o_bus_cmd_data,
  output logic [3:0]            o_bus_data_out,
  input  logic [3:0]            i_bus_data_in
);

  // Handshake: the core holds i_req (with op/addr/len/wdata stable) until it
  // sees the one-clock o_ack; requests are only accepted while o_busy is low.

  state_t              state_q, state_d;
  busop_t              op_q, op_d;
  logic [19:0]         addr_q, addr_d, pc_q, pc_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d, rd_index_q, rd_index_d;
  logic [4*MAXLEN-1:0] wdata_q, wdata_d;
  logic pc_valid_q, pc_valid_d, ack_q, ack_d, busy_q, busy_d;
  logic done_q, done_d, rd_valid_q, rd_valid_d;
  logic cyc_start, cyc_cmd_data, cyc_end, cyc_capture, pc_skip;
  logic [3:0] cyc_nibble;

  assign pc_skip     = (op_q == BUSOP_READ_PC) && pc_valid_q && (addr_q == pc_q);
  assign cyc_start   = (i_phase == 2'd0) && (state_q inside {S_CMD, S_ADDR, S_CMD2, S_DATA});
  assign cyc_capture = (state_q == S_DATA) && (op_q != BUSOP_WRITE_DP);

  always_comb begin : cycle_payload
    cyc_cmd_data = 1'b0;
    cyc_nibble   = BUSCMD_NOP;
    case (state_q)
      S_CMD:  cyc_nibble = (op_q == BUSOP_READ_PC) ? BUSCMD_LOAD_PC : BUSCMD_LOAD_DP;
      S_ADDR: begin
        cyc_cmd_data = 1'b1;
        cyc_nibble   = 4'(addr_q >> {cnt_q, 2'b00});
      end
      S_CMD2: cyc_nibble = BUSCMD_DP_WRITE;
      S_DATA: begin
        cyc_cmd_data = 1'b1;
        if (op_q == BUSOP_WRITE_DP) cyc_nibble = 4'(wdata_q >> {cnt_q, 2'b00});
      end
      default: ;
    endcase
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    ack_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_index_d = rd_index_q;
    if (done_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: if (i_req && !busy_q && op_legal(i_op)) begin
        op_d    = busop_t'(i_op);
        addr_d  = i_addr;
        len_d   = i_len;
        wdata_d = i_wdata;
        ack_d   = 1'b1;
        busy_d  = 1'b1;
        state_d = S_WAIT0;
        // Any DP access leaves the slave out of PC_READ mode.
        if (busop_t'(i_op) != BUSOP_READ_PC) pc_valid_d = 1'b0;
      end
      S_WAIT0: if (i_phase == 2'd3) begin
        state_d = pc_skip ? S_DATA : S_CMD;
        cnt_d   = '0;
      end
      S_CMD: if (cyc_end) state_d = S_ADDR;
      S_ADDR: if (cyc_end) begin
        if (cnt_q == LEN_W'(ADDR_NIBBLES - 1)) begin
          cnt_d   = '0;
          state_d = (op_q == BUSOP_WRITE_DP) ? S_CMD2 : S_DATA;
          if (op_q == BUSOP_READ_PC) pc_d = addr_q;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_CMD2: if (cyc_end) state_d = S_DATA;
      S_DATA: if (cyc_end) begin
        if (op_q == BUSOP_READ_PC) pc_d = pc_q + 20'd1;
        if (cyc_capture) begin
          rd_valid_d = 1'b1;
          rd_index_d = cnt_q;
        end
        if (cnt_q == len_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (op_q == BUSOP_READ_PC) pc_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      op_q       <= BUSOP_READ_PC;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      pc_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_index_q <= rd_index_d;
    end
  end

  saturn_bus_cycle u_cycle (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_phase       (i_phase),
    .i_start       (cyc_start),
    .i_cmd_data    (cyc_cmd_data),
    .i_nibble      (cyc_nibble),
    .i_capture     (cyc_capture),
    .i_bus_data_in (i_bus_data_in),
    .o_strobe      (o_bus_strobe),
    .o_cmd_data    (o_bus_cmd_data),
    .o_data_out    (o_bus_data_out),
    .o_sample      (o_rd_nibble),
    .o_cycle_end   (cyc_end)
  );

  assign o_ack      = ack_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_index = rd_index_q;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Directed and randomized checks of saturn_bus_ctrl against a transaction-level
// model of the expected bus cycle list, read returns and PC-skip tracking.
module tb_saturn_bus_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [1:0]  i_phase = 2'd0;
  logic        i_req = 1'b0;
  logic [1:0]  i_op = 2'd0;
  logic [19:0] i_addr = '0;
  logic [3:0]  i_len = '0;
  logic [63:0] i_wdata = '0;
  logic [3:0]  i_bus_data_in = '0;
  logic        o_ack, o_busy, o_rd_valid, o_done, o_bus_strobe, o_bus_cmd_data;
  logic [3:0]  o_rd_nibble, o_rd_index, o_bus_data_out;

  int checks = 0;
  int errors = 0;

  // Model: slave PC pointer as seen by the master.
  logic [19:0] m_pc = '0;
  bit          m_pc_valid = 1'b0;

  saturn_bus_ctrl #(.MAXLEN(16)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_phase        (i_phase),
    .i_req          (i_req),
    .i_op           (i_op),
    .i_addr         (i_addr),
    .i_len          (i_len),
    .i_wdata        (i_wdata),
    .o_ack          (o_ack),
    .o_busy         (o_busy),
    .o_rd_valid     (o_rd_valid),
    .o_rd_nibble    (o_rd_nibble),
    .o_rd_index     (o_rd_index),
    .o_done         (o_done),
    .o_bus_strobe   (o_bus_strobe),
    .o_bus_cmd_data (o_bus_cmd_data),
    .o_bus_data_out (o_bus_data_out),
    .i_bus_data_in  (i_bus_data_in)
  );

  // Clock and free-running bus phase.
  always #5 clk = ~clk;
  always @(posedge clk) i_phase <= i_phase + 2'd1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic request(input logic [1:0] op, input logic [19:0] addr,
                         input logic [3:0] len, input logic [63:0] wdata);
    bit got_ack;
    got_ack = 1'b0;
    i_op = op; i_addr = addr; i_len = len; i_wdata = wdata; i_req = 1'b1;
    for (int n = 0; n < 20 && !got_ack; n++) begin
      @(negedge clk);
      got_ack = o_ack;
    end
    i_req = 1'b0;
    check("ack", got_ack, 1);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [19:0] addr, input logic [3:0] len,
                         input logic [63:0] wdata, input bit poke_busy);
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    logic [3:0] drv_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] rd_exp;
    int n_data, clk_n, first_rise, done_clk, acks;
    bit prev_strobe, done_seen, done_rv, is_read;
    n_data  = int'(len) + 1;
    is_read = (op != 2'd2);
    if (!(op == 2'd0 && m_pc_valid && addr == m_pc)) begin
      exp_q.push_back({1'b0, (op == 2'd0) ? 4'h6 : 4'h7});
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, addr[4*i +: 4]});
      if (op == 2'd2) exp_q.push_back({1'b0, 4'h5});
    end
    for (int k = 0; k < n_data; k++) exp_q.push_back({1'b1, is_read ? 4'h0 : wdata[4*k +: 4]});

    request(op, addr, len, wdata);
    clk_n = 0; first_rise = -1; done_clk = 0; acks = 0;
    prev_strobe = 1'b0; done_seen = 1'b0; done_rv = 1'b0;
    while (!done_seen && clk_n < 400) begin
      @(negedge clk);
      clk_n++;
      if (o_ack) acks++;
      if (o_bus_strobe && !prev_strobe) begin
        obs_q.push_back({o_bus_cmd_data, o_bus_data_out});
        if (first_rise < 0) first_rise = clk_n;
        i_bus_data_in = 4'($urandom_range(0, 15));
        drv_q.push_back(i_bus_data_in);
      end
      prev_strobe = o_bus_strobe;
      if (o_rd_valid) rd_q.push_back({o_rd_index, o_rd_nibble});
      if (o_done) begin
        done_seen = 1'b1;
        done_clk  = clk_n;
        done_rv   = o_rd_valid;
      end
      i_req = poke_busy && clk_n >= 8 && clk_n < 12;
      if (poke_busy) i_op = 2'd1;
    end
    i_req = 1'b0;

    check("done_seen", done_seen, 1);
    check("n_cycles", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check("bus_cycle", obs_q[i], exp_q[i]);
    check("latency", done_clk - first_rise + 2, 4 * exp_q.size());
    check("ack_while_busy", acks, 0);
    if (is_read) begin
      check("rd_count", rd_q.size(), n_data);
      check("done_with_last_rd", done_rv, 1);
      for (int k = 0; k < n_data && k < rd_q.size() && drv_q.size() >= n_data; k++) begin
        rd_exp = {4'(k), drv_q[drv_q.size() - n_data + k]};
        check("rd_nibble", rd_q[k], rd_exp);
      end
    end else begin
      check("wr_no_rd", rd_q.size(), 0);
      check("done_no_rd", done_rv, 0);
    end
    @(negedge clk);
    check("busy_after_done", o_busy, 0);

    if (op == 2'd0) begin
      m_pc       = addr + 20'(n_data);
      m_pc_valid = 1'b1;
    end else begin
      m_pc_valid = 1'b0;
    end
  endtask

  initial begin
    int acks, rises, hits;
    bit prev;
    logic [1:0]  r_op;
    logic [19:0] r_addr;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_ack, o_busy, o_rd_valid, o_rd_nibble, o_rd_index, o_done,
           o_bus_strobe, o_bus_cmd_data, o_bus_data_out}, 0);
    i_reset = 1'b0;
    @(negedge clk);

    // Reserved op is ignored.
    i_op = 2'd3; i_req = 1'b1; acks = 0; rises = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_ack) acks++;
      if (o_bus_strobe) rises++;
    end
    i_req = 1'b0;
    check("op3_ack", acks, 0);
    check("op3_bus", rises, 0);

    // Directed transactions.
    run_txn(2'd0, 20'h12345, 4'd2, 64'h0, 1'b1);
    run_txn(2'd0, 20'h12348, 4'd0, 64'h0, 1'b0);
    run_txn(2'd2, 20'h00100, 4'd1, 64'h7E, 1'b0);
    run_txn(2'd0, 20'hFFFFE, 4'd3, 64'h0, 1'b0);
    run_txn(2'd0, 20'h00002, 4'd1, 64'h0, 1'b0);
    run_txn(2'd0, 20'hFFFFE, 4'd3, 64'h0, 1'b0);
    run_txn(2'd1, 20'h0ABCD, 4'd2, 64'h0, 1'b0);
    run_txn(2'd0, 20'h00002, 4'd1, 64'h0, 1'b0);

    // Abort mid-address with a valid tracked PC at 00004.
    request(2'd0, 20'h2468A, 4'd1, 64'h0);
    rises = 0; prev = 1'b0;
    for (int n = 0; n < 100 && rises < 4; n++) begin
      @(negedge clk);
      if (o_bus_strobe && !prev) rises++;
      prev = o_bus_strobe;
    end
    check("rises_before_reset", rises, 4);
    i_reset = 1'b1;
    @(negedge clk);
    check("strobe_after_reset", o_bus_strobe, 0);
    check("busy_after_reset", o_busy, 0);
    i_reset = 1'b0;
    hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done || o_bus_strobe) hits++;
    end
    check("quiet_after_abort", hits, 0);
    m_pc_valid = 1'b0;
    run_txn(2'd0, 20'h00004, 4'd0, 64'h0, 1'b0);
    run_txn(2'd0, 20'h2468A, 4'd1, 64'h0, 1'b0);

    // Randomized transactions, biased towards sequential PC fetches.
    for (int t = 0; t < 16; t++) begin
      r_op = 2'($urandom_range(0, 2));
      if (m_pc_valid && $urandom_range(0, 1) == 1) r_addr = m_pc;
      else if ($urandom_range(0, 3) == 0) r_addr = 20'hFFFF0 + 20'($urandom_range(0, 15));
      else r_addr = 20'($urandom);
      run_txn(r_op, r_addr, 4'($urandom_range(0, 15)), {$urandom, $urandom}, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
